// File: rtl/debug_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_uart_pkg : shared types and elaboration helpers for debug UART |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
package debug_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic int calc_div(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic bit div_ok(input int div);
    return div >= 2;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_uart_sync_fifo : 8-bit synchronous FIFO, accepts push when     |
// |                        full if a pop happens in the same cycle       |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module debug_uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_level != '0);
  assign w_do_push = i_push && ((r_level != LW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/debug_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_uart_tx_fifo : debug UART transmitter with write-side FIFO,    |
// |                      back-to-back 8N1/8N2 frames.                    |
// |                      Define DEBUG_UART_PARITY_EN for a parity bit.   |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module debug_uart_tx_fifo
  import debug_uart_pkg::*;
#(
  parameter int CLK_HZ     = 14_000_000,
  parameter int BIT_RATE   = 1_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
`ifdef DEBUG_UART_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_wr_en,
  input  logic [7:0]                  i_wr_data,
  input  logic                        i_clr_overflow,
  output logic                        o_uart_txd,
  output logic                        o_tx_busy,
  output logic                        o_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_overflow
);
  localparam int DIV = calc_div(CLK_HZ, BIT_RATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] C_DIV_LAST  = DW'(DIV - 1);
  localparam logic [2:0]    C_STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [2:0]    C_BIT_LAST  = 3'(DATA_BITS - 1);

  if (!div_ok(DIV)) begin : g_chk_div
    $error("debug_uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_chk_depth
    $error("debug_uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("debug_uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  uart_state_t   r_state;
  logic [DW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_ovf;
  logic          w_tick;
  logic          w_stop_end;
  logic          w_pop;
  logic          w_drop;
  logic          w_empty;
  logic          w_full;
  logic [7:0]    w_dout;
  logic [LW-1:0] w_level;
`ifdef DEBUG_UART_PARITY_EN
  logic          r_par;
`endif

  assign w_tick     = (r_div == C_DIV_LAST);
  assign w_stop_end = (r_state == STOP) && w_tick && (r_bit == C_STOP_LAST);
  assign w_pop      = !w_empty && ((r_state == IDLE) || w_stop_end);
  assign w_drop     = i_wr_en && w_full && !w_pop;

  debug_uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_wr_en),
    .i_pop   (w_pop),
    .i_din   (i_wr_data),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
`ifdef DEBUG_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_div <= (r_state == IDLE || w_tick) ? '0 : r_div + 1'b1;
      if (w_pop) begin
        r_shift <= w_dout;
`ifdef DEBUG_UART_PARITY_EN
        r_par   <= (^w_dout) ^ PARITY_ODD;
`endif
      end
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= START;
            r_txd   <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit == C_BIT_LAST) begin
`ifdef DEBUG_UART_PARITY_EN
              r_state <= PARITY;
              r_txd   <= r_par;
`else
              r_state <= STOP;
              r_txd   <= 1'b1;
`endif
              r_bit   <= '0;
            end else begin
              r_txd   <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
`ifdef DEBUG_UART_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_txd   <= 1'b1;
            r_bit   <= '0;
          end
        end
`endif
        STOP: begin
          // A queued byte starts its frame straight out of the last stop bit.
          if (w_tick) begin
            if (r_bit != C_STOP_LAST) begin
              r_bit <= r_bit + 1'b1;
            end else if (w_pop) begin
              r_state <= START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_txd   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // A dropped push outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_clr_overflow) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_uart_txd   = r_txd;
  assign o_tx_busy    = (r_state != IDLE) || (w_level != '0);
  assign o_fifo_full  = w_full;
  assign o_fifo_level = w_level;
  assign o_overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_debug_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_debug_uart_tx_fifo : directed bench with a serial-line scoreboard |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_debug_uart_tx_fifo;
  localparam int CLK_HZ     = 14_000_000;
  localparam int BIT_RATE   = 1_000_000;
  localparam int FIFO_DEPTH = 4;
  localparam int STOP_BITS  = 1;
  localparam int DIV        = CLK_HZ / BIT_RATE;
`ifdef DEBUG_UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB    = 1 + 8 + PB + STOP_BITS;
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_clr_overflow;
  logic       o_uart_txd;
  logic       o_tx_busy;
  logic       o_fifo_full;
  logic [2:0] o_fifo_level;
  logic       o_overflow;

  int         total = 0;
  int         bad   = 0;
  int         frames = 0;
  logic [7:0] exp_q[$];

  debug_uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BIT_RATE   (BIT_RATE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_wr_en        (i_wr_en),
    .i_wr_data      (i_wr_data),
    .i_clr_overflow (i_clr_overflow),
    .o_uart_txd     (o_uart_txd),
    .o_tx_busy      (o_tx_busy),
    .o_fifo_full    (o_fifo_full),
    .o_fifo_level   (o_fifo_level),
    .o_overflow     (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (o_tx_busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [11:0] frame_bits(input logic [7:0] d);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef DEBUG_UART_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  // Line monitor: every cycle of a frame must carry the expected bit value.
  initial begin : monitor
    logic [11:0] fb;
    logic [7:0]  d;
    int          wrong;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_uart_txd === 1'b0) begin
        check("start_has_queued_byte", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          d       = exp_q.pop_front();
          fb      = frame_bits(d);
          wrong   = 0;
          aborted = 1'b0;
          for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (o_uart_txd !== fb[k / DIV]) wrong++;
          end
          if (!aborted) begin
            frames++;
            check($sformatf("frame_%02h_wrong_cycles", d), wrong, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         n;
    int         f0;
    int         idle_bad;
    logic [7:0] b5 [5];
    b5 = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst_n = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd",   int'(o_uart_txd), 1);
    check("rst_busy",  int'(o_tx_busy), 0);
    check("rst_full",  int'(o_fifo_full), 0);
    check("rst_level", int'(o_fifo_level), 0);
    check("rst_ovf",   int'(o_overflow), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte: latency, frame timing, busy length.
    i_wr_en = 1'b1; i_wr_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk); i_wr_en = 1'b0;
    check("t1_level_after_write", int'(o_fifo_level), 1);
    check("t1_busy_after_write",  int'(o_tx_busy), 1);
    check("t1_txd_before_pop",    int'(o_uart_txd), 1);
    @(negedge clk);
    check("t1_txd_start",         int'(o_uart_txd), 0);
    check("t1_level_after_pop",   int'(o_fifo_level), 0);
    wait_idle(3 * FRAME, n);
    check("t1_busy_cycles", n, FRAME);
    check("t1_frames", frames, 1);

    // Three back-to-back writes, contiguous frames.
    f0 = frames;
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk); i_wr_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk); i_wr_data = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge clk); i_wr_en = 1'b0;
    check("t2_level_after_writes", int'(o_fifo_level), 2);
    wait_idle(4 * FRAME, n);
    check("t2_busy_cycles", n, 3 * FRAME - 1);
    check("t2_frames", frames - f0, 3);
    check("t2_queue_empty", exp_q.size(), 0);

    // Overflow while the FSM is busy.
    f0 = frames;
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk); i_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    i_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_wr_data = b5[i];
      if (i < 4) exp_q.push_back(b5[i]);
      @(negedge clk);
      if (i == 3) begin
        check("t3_full_after_4",  int'(o_fifo_full), 1);
        check("t3_level_after_4", int'(o_fifo_level), 4);
        check("t3_ovf_after_4",   int'(o_overflow), 0);
      end
    end
    i_wr_en = 1'b0;
    check("t3_ovf_after_5",   int'(o_overflow), 1);
    check("t3_level_after_5", int'(o_fifo_level), 4);
    i_clr_overflow = 1'b1;
    @(negedge clk); i_clr_overflow = 1'b0;
    check("t3_ovf_cleared", int'(o_overflow), 0);
    wait_idle(7 * FRAME, n);
    check("t3_frames", frames - f0, 5);
    check("t3_queue_empty", exp_q.size(), 0);

    // Full FIFO: clear-vs-drop priority, then push coinciding with STOP-end pop.
    f0 = frames;
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk); i_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    i_wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_wr_data = 8'hA1 + 8'(i);
      exp_q.push_back(i_wr_data);
      @(negedge clk);
    end
    check("t4_level_full", int'(o_fifo_level), 4);
    i_wr_data = 8'h99; i_clr_overflow = 1'b1;
    @(negedge clk); i_wr_en = 1'b0; i_clr_overflow = 1'b0;
    check("t4_ovf_set_wins", int'(o_overflow), 1);
    check("t4_level_after_drop", int'(o_fifo_level), 4);
    i_clr_overflow = 1'b1;
    @(negedge clk); i_clr_overflow = 1'b0;
    check("t4_ovf_cleared", int'(o_overflow), 0);
    repeat (FRAME - 8) @(negedge clk);
    check("t4_level_before_pop", int'(o_fifo_level), 4);
    i_wr_en = 1'b1; i_wr_data = 8'h77; exp_q.push_back(8'h77);
    @(negedge clk); i_wr_en = 1'b0;
    check("t4_level_push_with_pop", int'(o_fifo_level), 4);
    check("t4_ovf_push_with_pop",   int'(o_overflow), 0);
    check("t4_full_push_with_pop",  int'(o_fifo_full), 1);
    check("t4_txd_next_start",      int'(o_uart_txd), 0);
    wait_idle(7 * FRAME, n);
    check("t4_frames", frames - f0, 6);
    check("t4_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a data bit.
    f0 = frames;
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 8'h00; exp_q.push_back(8'h00);
    @(negedge clk); i_wr_data = 8'hF0; exp_q.push_back(8'hF0);
    @(negedge clk); i_wr_en = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    check("t5_txd_pre_reset",   int'(o_uart_txd), 0);
    check("t5_level_pre_reset", int'(o_fifo_level), 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_txd_async",   int'(o_uart_txd), 1);
    check("t5_busy_async",  int'(o_tx_busy), 0);
    check("t5_level_async", int'(o_fifo_level), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (o_uart_txd !== 1'b1 || o_tx_busy !== 1'b0) idle_bad++;
    end
    check("t5_idle_after_release", idle_bad, 0);
    check("t5_frames", frames - f0, 0);

    // Frame length with 0x07 (parity bit 1 when parity is built in).
    f0 = frames;
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 8'h07; exp_q.push_back(8'h07);
    @(negedge clk); i_wr_en = 1'b0;
    @(negedge clk);
    check("t6_txd_start", int'(o_uart_txd), 0);
    wait_idle(3 * FRAME, n);
    check("t6_busy_cycles", n, FRAME);
    check("t6_frames", frames - f0, 1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
